// File: rtl/apb_master_pkg.sv
// Shared types for the APB command master: FSM state encoding and the
// response record as seen by the bridge's default 8-bit data path.
package apb_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam int RSP_W = 8;

    typedef struct packed {
        logic [RSP_W-1:0] rdata;
        logic             err;
        logic             timeout;
    } rsp_t;

endpackage

// File: rtl/apb_cmd_master.sv
// APB3 master: takes one valid/ready command at a time, runs the SETUP/ACCESS
// handshake, and parks the outcome in a one-entry response register. Transfers
// whose PREADY wait reaches TIMEOUT cycles are aborted with err+timeout set.
module apb_cmd_master
    import apb_master_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             PCLK,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [WIDTH-1:0] cmd_addr,
    input  logic [WIDTH-1:0] cmd_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic             rsp_timeout,
    output logic             PSEL,
    output logic             PENABLE,
    output logic             PWRITE,
    output logic [WIDTH-1:0] PADDR,
    output logic [WIDTH-1:0] PWDATA,
    input  logic             PREADY,
    input  logic             PSLVERR,
    input  logic [WIDTH-1:0] PRDATA
);

    // Counter must be able to hold TIMEOUT itself; a disabled timeout still
    // needs a 1-bit counter so the logic stays well-formed.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] wait_q;
    logic [CNT_W:0]   wait_inc;
    logic             accept;
    logic             tmo_hit;
    logic             rsp_load;

    // APB strobes decode straight from state so reset drops them asynchronously
    assign PSEL    = (state_q != IDLE);
    assign PENABLE = (state_q == ACCESS);

    // Handshake and timeout detection; timeout fires when this low-PREADY
    // cycle would bring the wait count up to TIMEOUT
    always_comb begin
        cmd_ready = (state_q == IDLE) && (!rsp_valid || rsp_ready);
        accept    = cmd_valid && cmd_ready;
        wait_inc  = {1'b0, wait_q} + 1'b1;
        tmo_hit   = (TIMEOUT > 0) && (int'(wait_inc) >= TIMEOUT);
    end

    // Next-state logic and response-load strobe
    always_comb begin
        state_d  = state_q;
        rsp_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = SETUP;
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (PREADY || tmo_hit) begin
                    state_d  = IDLE;
                    rsp_load = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge PCLK or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Saturating PREADY wait counter, cleared as the transfer enters SETUP
    always_ff @(posedge PCLK or posedge reset) begin
        if (reset) begin
            wait_q <= '0;
        end else if (accept) begin
            wait_q <= '0;
        end else if (state_q == ACCESS && !PREADY && wait_q != '1) begin
            wait_q <= wait_inc[CNT_W-1:0];
        end
    end

    // APB address/data/direction change only on command accept, so they are
    // stable across SETUP and ACCESS and hold afterwards
    always_ff @(posedge PCLK or posedge reset) begin
        if (reset) begin
            PWRITE <= 1'b0;
            PADDR  <= '0;
            PWDATA <= '0;
        end else if (accept) begin
            PWRITE <= cmd_write;
            PADDR  <= cmd_addr;
            PWDATA <= cmd_wdata;
        end
    end

    // One-entry response buffer; loading only happens in ACCESS, when no
    // command can be accepted, so load and consume never need arbitration
    always_ff @(posedge PCLK or posedge reset) begin
        if (reset) begin
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else if (rsp_load) begin
            rsp_valid <= 1'b1;
            if (PREADY) begin
                rsp_rdata   <= PWRITE ? '0 : PRDATA;
                rsp_err     <= PSLVERR;
                rsp_timeout <= 1'b0;
            end else begin
                rsp_rdata   <= '0;
                rsp_err     <= 1'b1;
                rsp_timeout <= 1'b1;
            end
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: doc/apb_cmd_master.md
# apb_cmd_master

APB master that turns a simple valid/ready command stream into APB3 transfers toward the bridge's APB slave port, and returns read data and error status on a valid/ready response stream. It sits directly upstream of the APB-to-SPI bridge, on the PCLK domain, and is how firmware-side logic and test sequencers push bytes into the SPI write FIFO and pull bytes from the read FIFO. It handles one transfer at a time, holds a one-entry response buffer, and aborts any transfer whose PREADY wait exceeds a programmable limit.

## Interface
- WIDTH, 8, width of PADDR, PWDATA, PRDATA, cmd_addr, cmd_wdata and rsp_rdata.
- TIMEOUT, 16, number of ACCESS cycles with PREADY low before the transfer is aborted; 0 disables the timeout.

Ports:
- PCLK  in  1  single clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = APB write, 0 = APB read.
- cmd_addr  in  WIDTH  target PADDR.
- cmd_wdata  in  WIDTH  write data; ignored for reads.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  response consumed when high together with rsp_valid.
- rsp_rdata  out  WIDTH  PRDATA for reads; 0 for writes and timeouts.
- rsp_err  out  1  PSLVERR sampled at completion, or 1 on timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- PSEL, PENABLE, PWRITE  out  1  APB control.
- PADDR, PWDATA  out  WIDTH  APB address and write data.
- PREADY, PSLVERR  in  1  APB slave status.
- PRDATA  in  WIDTH  APB read data.

## Operation
- FSM states: IDLE, SETUP, ACCESS. Encoding is defined in the package.
- IDLE: cmd_ready = (state==IDLE) && (!rsp_valid || rsp_ready). This is combinational. On accept, latch cmd_write/addr/wdata into PWRITE/PADDR/PWDATA and go to SETUP.
- SETUP: PSEL=1, PENABLE=0. Unconditionally go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1. Sample PREADY every cycle.
  - PREADY=1: load rsp_rdata (PRDATA if read, else 0), rsp_err=PSLVERR, rsp_timeout=0; set rsp_valid; go to IDLE.
  - PREADY=0: increment the wait counter. When the counter reaches TIMEOUT (TIMEOUT>0), abort: rsp_rdata=0, rsp_err=1, rsp_timeout=1, rsp_valid=1; go to IDLE.
- The wait counter clears on entry to SETUP. Its width is $clog2(TIMEOUT+1), minimum 1. It saturates and never wraps.
- rsp_valid clears on rsp_valid && rsp_ready unless a new response loads in the same cycle. A new response can only load in ACCESS, so accept and consume never collide in that state.
- PADDR, PWDATA and PWRITE hold their last values after a transfer. They change only on command accept.
- PSLVERR and PRDATA are ignored outside the completing ACCESS cycle.

## Timing
- Reset values: PSEL=PENABLE=PWRITE=0, PADDR=PWDATA=0, rsp_valid=rsp_err=rsp_timeout=0, rsp_rdata=0, state=IDLE, so cmd_ready=1.
- Command accepted at edge k:
  - After edge k+1, SETUP: PSEL=1, PENABLE=0.
  - After edge k+2, ACCESS: PENABLE=1.
- With zero wait states, PREADY=1 is sampled at edge k+3. rsp_valid is then high and PSEL/PENABLE are low from k+3.
- Minimum command-to-response latency is 3 cycles, plus N for N wait states.
- Back-to-back throughput: with rsp_ready held high, the next command can be accepted in the cycle rsp_valid rises. That gives one transfer per 3 cycles.
- Timeout: with PREADY held low, the abort occurs at the edge ending the TIMEOUT-th ACCESS cycle. Total latency is TIMEOUT+2 cycles.
- If rsp_valid is stuck high with rsp_ready low, cmd_ready stays low. No transfer starts and no response is lost.
- Reset asserted mid-transfer: PSEL/PENABLE drop asynchronously, and the in-flight command and held response are discarded.
- APB rule: PADDR, PWRITE and PWDATA are stable from SETUP through completion.

## Structure
- Package apb_master_pkg contains:
  - the state_t enum (IDLE, SETUP, ACCESS);
  - a rsp_t struct {rdata, err, timeout} sized by WIDTH, typedef'd for WIDTH=8 as the bridge default.
- No sub-module is needed. The FSM, wait counter and one-entry response register live in one module.

## Test plan
- Write, zero wait: cmd write addr 0x04 data 0xA5.
  - PSEL rises at k+1 and PENABLE at k+2, with PADDR=0x04 and PWDATA=0xA5.
  - rsp_valid at k+3 with rsp_err=0 and rsp_rdata=0x00.
- Read with wait states: PREADY low for 3 ACCESS cycles, PRDATA=0x3C.
  - rsp_valid 6 cycles after accept with rsp_rdata=0x3C.
  - PADDR stays stable throughout.
- Slave error: PSLVERR=1 with PREADY=1 on a read.
  - rsp_err=1, rsp_timeout=0, and PRDATA is returned.
- Timeout: TIMEOUT=16 and PREADY held low.
  - Abort 18 cycles after accept with rsp_err=1, rsp_timeout=1 and rsp_rdata=0.
  - PSEL drops the same edge.
- Backpressure: rsp_ready low for 10 cycles after the first response, with a second command offered.
  - cmd_ready stays 0 and no PSEL appears.
  - On the rsp_ready pulse, the second command is accepted in that same cycle.
- Reset mid-ACCESS: assert reset during PENABLE=1.
  - PSEL/PENABLE/rsp_valid go 0 immediately.
  - After release, cmd_ready=1 and a new write completes normally.
